// File: rtl/lap_run_ctrl.sv
// Run/lap sequencer for the stopwatch time datapath.
// Generates the counter-chain enable and clear, and selects whether the digit
// decoders see live counter values or a frozen lap snapshot. Loss of clock-manager
// lock forces the sequencer back to WAIT_LOCK.
// Optional feature: define LAP_COUNT_EN to add the lap_num_o lap counter output.
module lap_run_ctrl #(
    parameter int unsigned DIGITS    = 5,
    parameter int unsigned LAP_CNT_W = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  dcm_lock_i,
    input  logic                  strtstop_i,
    input  logic                  lap_i,
    input  logic [4*DIGITS-1:0]   time_in_i,
    output logic                  run_ce_o,
    output logic                  cnt_clr_o,
    output logic [4*DIGITS-1:0]   time_out_o,
    output logic                  hold_o,
    output logic [2:0]            state_o
`ifdef LAP_COUNT_EN
    ,
    output logic [LAP_CNT_W-1:0]  lap_num_o
`endif
);

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StZero     = 3'd1,
        StRun      = 3'd2,
        StLapHold  = 3'd3,
        StStop     = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                ss_q, lap_q;
    logic                ss_p, lap_p;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic                run_ce_q, run_ce_d;
    logic                cnt_clr_q, cnt_clr_d;
    logic                hold_q, hold_d;
    logic [4*DIGITS-1:0] time_out_q, time_out_d;

    // Next state, snapshot capture and output decode from the next state
    always_comb begin
        ss_p    = strtstop_i & ~ss_q;
        lap_p   = lap_i & ~lap_q;
        state_d = state_q;
        snap_d  = snap_q;
        if (!dcm_lock_i) begin
            state_d = StWaitLock;
            snap_d  = '0;
        end else begin
            case (state_q)
                StWaitLock: state_d = StZero;
                StZero:     if (ss_p) state_d = StRun;
                StRun: begin
                    // Start/stop wins over a coincident lap edge
                    if (ss_p) begin
                        state_d = StStop;
                    end else if (lap_p) begin
                        state_d = StLapHold;
                        snap_d  = time_in_i;
                    end
                end
                StLapHold: begin
                    if (ss_p)       state_d = StStop;
                    else if (lap_p) state_d = StRun;
                end
                StStop: begin
                    if (ss_p)       state_d = StRun;
                    else if (lap_p) state_d = StZero;
                end
                default:    state_d = StWaitLock;
            endcase
        end

        run_ce_d  = (state_d == StRun) || (state_d == StLapHold);
        cnt_clr_d = (state_d == StWaitLock) || (state_d == StZero);
        hold_d    = (state_d == StLapHold);
        time_out_d = hold_d ? snap_d : time_in_i;
    end

    // State, edge history and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StWaitLock;
            ss_q       <= 1'b1;
            lap_q      <= 1'b1;
            snap_q     <= '0;
            run_ce_q   <= 1'b0;
            cnt_clr_q  <= 1'b1;
            hold_q     <= 1'b0;
            time_out_q <= '0;
        end else begin
            state_q    <= state_d;
            ss_q       <= strtstop_i;
            lap_q      <= lap_i;
            snap_q     <= snap_d;
            run_ce_q   <= run_ce_d;
            cnt_clr_q  <= cnt_clr_d;
            hold_q     <= hold_d;
            time_out_q <= time_out_d;
        end
    end

    assign run_ce_o   = run_ce_q;
    assign cnt_clr_o  = cnt_clr_q;
    assign hold_o     = hold_q;
    assign time_out_o = time_out_q;
    assign state_o    = state_q;

`ifdef LAP_COUNT_EN
    logic [LAP_CNT_W-1:0] lap_num_q, lap_num_d;

    // Lap counter: counts RUN->LAPHOLD entries, cleared whenever the chain is cleared
    always_comb begin
        lap_num_d = lap_num_q;
        if (state_d == StWaitLock || state_d == StZero) begin
            lap_num_d = '0;
        end else if (state_q == StRun && state_d == StLapHold) begin
            lap_num_d = lap_num_q + LAP_CNT_W'(1);
        end
    end

    // Lap counter register
    always_ff @(posedge clk_i) begin
        if (reset_i) lap_num_q <= '0;
        else         lap_num_q <= lap_num_d;
    end

    assign lap_num_o = lap_num_q;
`endif

endmodule
